// File: rtl/b08_seq_driver.sv
// b08_seq_driver: feeds query words to a b08 engine, runs START for a fixed window, returns tagged O results.
module b08_seq_driver #(
  parameter int RUN_CYCLES    = 12,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_DATA,
  output logic             START,
  output logic [7:0]       I,
  input  logic [3:0]       O,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [3:0]       RES_DATA,
  output logic [7:0]       RES_TAG,
  output logic             BUSY,
  output logic [CNT_W-1:0] DONE_CNT
);
  localparam int MAXC = RUN_CYCLES > SETTLE_CYCLES ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_q, start_d, vld_q, vld_d;
  logic [7:0] i_q, i_d, tag_q, tag_d;
  logic [3:0] res_q, res_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic run_end, set_end;
  assign run_end   = cnt_q == CW'(RUN_CYCLES);
  assign set_end   = cnt_q == CW'(SETTLE_CYCLES);
  assign IN_READY  = state_q == IDLE;
  assign BUSY      = state_q != IDLE;
  assign START     = start_q;
  assign I         = i_q;
  assign RES_VALID = vld_q;
  assign RES_DATA  = res_q;
  assign RES_TAG   = tag_q;
  assign DONE_CNT  = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    vld_d   = vld_q;
    i_d     = i_q;
    tag_d   = tag_q;
    res_d   = res_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (IN_VALID) begin
        i_d     = IN_DATA;
        tag_d   = IN_DATA;
        start_d = 1'b1;
        cnt_d   = CW'(1);
        state_d = RUN;
      end
      RUN: if (run_end) begin
        start_d = 1'b0;
        cnt_d   = CW'(1);
        state_d = SETTLE;
      end else cnt_d = cnt_q + CW'(1);
      // O is captured only on the last settle edge, so it is sampled once per query
      SETTLE: if (set_end) begin
        res_d   = O;
        vld_d   = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + CW'(1);
      RESP: if (RES_READY) begin
        vld_d   = 1'b0;
        done_d  = done_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      i_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      i_q     <= i_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_b08_seq_driver.sv
// tb_b08_seq_driver: directed checks of the b08 driver, defaults plus a fast 4-bit-counter instance.
module tb_b08_seq_driver;
  logic CLOCK = 0, RESET = 0;
  logic IN_VALID = 0, IN_READY, START, RES_VALID, RES_READY = 0, BUSY;
  logic [7:0] IN_DATA = 0, I, RES_TAG;
  logic [3:0] O = 0, RES_DATA;
  logic [15:0] DONE_CNT;
  logic in_valid2 = 0, in_ready2, start2, res_valid2, res_ready2 = 0, busy2;
  logic [7:0] in_data2 = 0, i2, res_tag2;
  logic [3:0] o2 = 0, res_data2;
  logic [3:0] done_cnt2;
  int vecs = 0, errs = 0;

  b08_seq_driver dut (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .START(START), .I(I), .O(O), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_TAG(RES_TAG), .BUSY(BUSY), .DONE_CNT(DONE_CNT)
  );
  b08_seq_driver #(.RUN_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(4)) dut2 (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(in_valid2), .IN_READY(in_ready2), .IN_DATA(in_data2),
    .START(start2), .I(i2), .O(o2), .RES_VALID(res_valid2), .RES_READY(res_ready2),
    .RES_DATA(res_data2), .RES_TAG(res_tag2), .BUSY(busy2), .DONE_CNT(done_cnt2)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_resp(input string nm);
    int n = 0;
    while (RES_VALID !== 1'b1 && n < 40) begin tick(); n++; end
    vecs++; if (RES_VALID !== 1'b1) begin errs++; $display("FAIL %s_timeout got=%b exp=1", nm, RES_VALID); end
  endtask

  task automatic handshake(input logic [15:0] exp_done);
    RES_READY = 1;
    tick();
    RES_READY = 0;
    vecs++; if (RES_VALID !== 1'b0) begin errs++; $display("FAIL hs_valid got=%b exp=0", RES_VALID); end
    vecs++; if (DONE_CNT !== exp_done) begin errs++; $display("FAIL hs_done got=%0d exp=%0d", DONE_CNT, exp_done); end
    vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL hs_in_ready got=%b exp=1", IN_READY); end
  endtask

  task automatic test_reset();
    bit start_seen = 0;
    RESET = 1;
    for (int n = 0; n < 3; n++) begin tick(); if (START !== 1'b0) start_seen = 1; end
    RESET = 0;
    vecs++; if (start_seen) begin errs++; $display("FAIL rst_start got=1 exp=0"); end
    vecs++; if ({I, RES_VALID, RES_DATA, RES_TAG, BUSY} !== '0) begin errs++; $display("FAIL rst_outs got=%h_%b_%h_%h_%b exp=0", I, RES_VALID, RES_DATA, RES_TAG, BUSY); end
    vecs++; if (DONE_CNT !== 16'd0) begin errs++; $display("FAIL rst_done got=%0d exp=0", DONE_CNT); end
    tick();
    vecs++; if (IN_READY !== 1'b1) begin errs++; $display("FAIL rst_in_ready got=%b exp=1", IN_READY); end
    vecs++; if (START !== 1'b0) begin errs++; $display("FAIL idle_start got=%b exp=0", START); end
  endtask

  task automatic test_single();
    IN_DATA = 8'hA5; IN_VALID = 1; O = 4'h0;
    tick();
    IN_VALID = 0;
    vecs++; if ({START, BUSY, IN_READY} !== 3'b110) begin errs++; $display("FAIL acc_flags got=%b exp=110", {START, BUSY, IN_READY}); end
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == 12) O = 4'h9;
      vecs++; if (START !== (j < 12)) begin errs++; $display("FAIL single_start[%0d] got=%b exp=%b", j, START, j < 12); end
      vecs++; if (I !== 8'hA5) begin errs++; $display("FAIL single_i[%0d] got=%h exp=a5", j, I); end
      vecs++; if (RES_VALID !== (j == 14)) begin errs++; $display("FAIL single_valid[%0d] got=%b exp=%b", j, RES_VALID, j == 14); end
    end
    vecs++; if (RES_DATA !== 4'h9) begin errs++; $display("FAIL single_data got=%h exp=9", RES_DATA); end
    vecs++; if (RES_TAG !== 8'hA5) begin errs++; $display("FAIL single_tag got=%h exp=a5", RES_TAG); end
    handshake(16'd1);
    vecs++; if (BUSY !== 1'b0 || I !== 8'hA5) begin errs++; $display("FAIL single_idle busy=%b i=%h exp busy=0 i=a5", BUSY, I); end
  endtask

  task automatic test_back_pressure();
    IN_DATA = 8'h5A; IN_VALID = 1; O = 4'h3;
    tick();
    IN_VALID = 0;
    wait_resp("bp");
    IN_DATA = 8'h3C; IN_VALID = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      vecs++; if ({RES_VALID, RES_DATA, RES_TAG} !== {1'b1, 4'h3, 8'h5A}) begin errs++; $display("FAIL bp_hold[%0d] got=%b/%h/%h exp=1/3/5a", n, RES_VALID, RES_DATA, RES_TAG); end
      vecs++; if ({IN_READY, BUSY, START} !== 3'b010) begin errs++; $display("FAIL bp_flags[%0d] got=%b exp=010", n, {IN_READY, BUSY, START}); end
    end
    handshake(16'd2);
    tick();
    IN_VALID = 0;
    vecs++; if ({START, I, RES_TAG} !== {1'b1, 8'h3C, 8'h3C}) begin errs++; $display("FAIL bp_next got=%b/%h/%h exp=1/3c/3c", START, I, RES_TAG); end
    O = 4'hC;
    wait_resp("bp2");
    vecs++; if ({RES_DATA, RES_TAG} !== {4'hC, 8'h3C}) begin errs++; $display("FAIL bp2_res got=%h/%h exp=c/3c", RES_DATA, RES_TAG); end
    handshake(16'd3);
  endtask

  task automatic test_sampling();
    IN_DATA = 8'h11; IN_VALID = 1; O = 4'h1;
    tick();
    IN_VALID = 0;
    for (int j = 1; j <= 14; j++) begin tick(); if (j == 13) O = 4'h7; end
    vecs++; if ({RES_VALID, RES_DATA} !== {1'b1, 4'h7}) begin errs++; $display("FAIL samp_late got=%b/%h exp=1/7", RES_VALID, RES_DATA); end
    handshake(16'd4);
    IN_DATA = 8'h22; IN_VALID = 1; O = 4'h1;
    tick();
    IN_VALID = 0;
    for (int j = 1; j <= 14; j++) tick();
    vecs++; if ({RES_VALID, RES_DATA} !== {1'b1, 4'h1}) begin errs++; $display("FAIL samp_edge got=%b/%h exp=1/1", RES_VALID, RES_DATA); end
    O = 4'h7;
    tick();
    vecs++; if (RES_DATA !== 4'h1) begin errs++; $display("FAIL samp_after got=%h exp=1", RES_DATA); end
    handshake(16'd5);
  endtask

  task automatic test_reset_mid_run();
    bit vld_seen = 0;
    IN_DATA = 8'h44; IN_VALID = 1; O = 4'h2;
    tick();
    IN_VALID = 0;
    for (int j = 1; j <= 4; j++) tick();
    vecs++; if (START !== 1'b1) begin errs++; $display("FAIL mid_pre_start got=%b exp=1", START); end
    RESET = 1;
    tick();
    RESET = 0;
    vecs++; if ({START, RES_VALID, BUSY, IN_READY} !== 4'b0001) begin errs++; $display("FAIL mid_flags got=%b exp=0001", {START, RES_VALID, BUSY, IN_READY}); end
    vecs++; if (DONE_CNT !== 16'd0) begin errs++; $display("FAIL mid_done got=%0d exp=0", DONE_CNT); end
    for (int n = 0; n < 15; n++) begin tick(); if (RES_VALID !== 1'b0) vld_seen = 1; end
    vecs++; if (vld_seen) begin errs++; $display("FAIL mid_no_valid got=1 exp=0"); end
    IN_DATA = 8'h55; IN_VALID = 1; O = 4'h6;
    tick();
    IN_VALID = 0;
    for (int j = 1; j <= 14; j++) tick();
    vecs++; if ({RES_VALID, RES_DATA, RES_TAG} !== {1'b1, 4'h6, 8'h55}) begin errs++; $display("FAIL mid_next got=%b/%h/%h exp=1/6/55", RES_VALID, RES_DATA, RES_TAG); end
    handshake(16'd1);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int n = 0; n < 17; n++) begin
      d = 8'(n * 7 + 3);
      in_valid2 = 1; in_data2 = d; o2 = ~d[3:0];
      tick();
      vecs++; if ({start2, i2} !== {1'b1, d}) begin errs++; $display("FAIL wrap_acc[%0d] got=%b/%h exp=1/%h", n, start2, i2, d); end
      tick();
      vecs++; if ({start2, res_valid2} !== 2'b00) begin errs++; $display("FAIL wrap_run[%0d] got=%b exp=00", n, {start2, res_valid2}); end
      tick();
      vecs++; if ({res_valid2, res_data2, res_tag2} !== {1'b1, ~d[3:0], d}) begin errs++; $display("FAIL wrap_res[%0d] got=%b/%h/%h exp=1/%h/%h", n, res_valid2, res_data2, res_tag2, ~d[3:0], d); end
      res_ready2 = 1;
      tick();
      res_ready2 = 0;
      vecs++; if ({res_valid2, done_cnt2} !== {1'b0, 4'(n + 1)}) begin errs++; $display("FAIL wrap_done[%0d] got=%b/%0d exp=0/%0d", n, res_valid2, done_cnt2, 4'(n + 1)); end
    end
    in_valid2 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_sampling();
    test_reset_mid_run();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
